exc_vector_unit: RTL

- Parametrised successor to the two-input EX PC-select mux in the multicycle MIPS datapath.
- Accepts N_CAUSES exception requests (invalid opcode, overflow, divide-by-zero, ...) and picks the highest-priority one.
- Captures EPC and cause, fetches the handler address from a memory vector table (VEC_BASE + cause) with configurable memory latency, then drives it onto the PC input with a one-cycle PC write pulse.
- With no exception in progress, passes the normal PCSource value straight through.

---
 rtl/exc_pkg.sv | 16 +
 rtl/exc_prio_enc.sv | 22 ++
 rtl/exc_vector_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception vectoring unit.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    JUMP
  } exc_state_t;

  localparam int CAUSE_OPCODE = 0;
  localparam int CAUSE_OVF    = 1;
  localparam int CAUSE_DIV0   = 2;

  localparam int EXC_VEC_BASE = 253;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder; valid is high when any request is set.
module exc_prio_enc #(
  parameter int N_CAUSES = 3,
  parameter int CAUSE_W  = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1
) (
  input  logic [N_CAUSES-1:0] req,
  output logic [CAUSE_W-1:0]  idx,
  output logic                valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_CAUSES; i++) begin
      if (req[i] && !valid) begin
        idx   = CAUSE_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_vector_unit.sv
// Exception PC-select unit: latches EPC/cause, reads the handler address from
// the vector table, then issues a one-cycle PC write to the handler.
module exc_vector_unit
  import exc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int N_CAUSES = 3,
  parameter int CAUSE_W  = (N_CAUSES > 1) ? $clog2(N_CAUSES) : 1,
  parameter int VEC_BASE = EXC_VEC_BASE,
  parameter int VEC_W    = 8,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CAUSES-1:0] exc_req,
  input  logic [DATA_W-1:0]   epc_in,
  input  logic [DATA_W-1:0]   pc_normal,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic [DATA_W-1:0]   epc_out,
  output logic                epc_we,
  output logic [CAUSE_W-1:0]  cause_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic                pc_we,
  output logic                busy,
  output logic                exc_ack
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("exc_vector_unit: MEM_LAT must be at least 1");
  end
  if (VEC_W > DATA_W) begin : g_bad_vecw
    $error("exc_vector_unit: VEC_W must not exceed DATA_W");
  end
  if (DATA_W < 63 && ((longint'(VEC_BASE) + longint'(N_CAUSES) - 1) >> DATA_W) != 0) begin : g_bad_base
    $error("exc_vector_unit: VEC_BASE + N_CAUSES - 1 does not fit in DATA_W");
  end

  exc_state_t          state_q, state_d;
  logic [CAUSE_W-1:0]  cause_q;
  logic [DATA_W-1:0]   epc_q;
  logic [DATA_W-1:0]   vec_q;
  logic [LAT_W-1:0]    lat_cnt;
  logic [CAUSE_W-1:0]  enc_idx;
  logic                enc_valid;
  logic                unused_rdata;

  // Only the low VEC_W bits of the vector entry are meaningful.
  assign unused_rdata = ^mem_rdata;

  exc_prio_enc #(
    .N_CAUSES (N_CAUSES),
    .CAUSE_W  (CAUSE_W)
  ) u_prio (
    .req   (exc_req),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      vec_q   <= '0;
      lat_cnt <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (enc_valid) begin
            cause_q <= enc_idx;
            epc_q   <= epc_in;
            lat_cnt <= LAT_LOAD;
          end
        end
        FETCH: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
          else               vec_q   <= DATA_W'(mem_rdata[VEC_W-1:0]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_out   = pc_normal;
    pc_we    = 1'b0;
    exc_ack  = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    epc_we   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_valid) state_d = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = DATA_W'(VEC_BASE) + DATA_W'(cause_q);
        // lat_cnt only counts down, so it equals the load value in the first cycle alone
        epc_we   = (lat_cnt == LAT_LOAD);
        if (lat_cnt == '0) state_d = JUMP;
      end
      JUMP: begin
        busy    = 1'b1;
        pc_out  = vec_q;
        pc_we   = 1'b1;
        exc_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign epc_out   = epc_q;
  assign cause_out = cause_q;

endmodule
